// File: rtl/ram_port_arbiter_if.sv
// Bundles both requester command/return ports and the RAM-side bus of ram_port_arbiter.
// slave is the arbiter view; master is the requesters-plus-RAM environment view.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_dout,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output ram_cs, ram_we, ram_addr, ram_din
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_dout,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  ram_cs, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Registers one RAM command per transfer and routes read data back to its issuer.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int PIPE_TOP = int'(RD_LAT) - 1;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e              pri_q;
  pri_e              pri_d;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              xfer_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  logic              cs_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_id_q;
  logic              rvalid0_q;
  logic              rvalid1_q;

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) pri_q <= PRI0;
    else     pri_q <= pri_d;
  end

  // Grant decode and pointer advance; pointer moves to the loser only on a transfer
  always_comb begin
    pri_d  = pri_q;
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (bus.req0 && (!bus.req1 || pri_q == PRI0)) gnt0_c = 1'b1;
      else if (bus.req1)                            gnt1_c = 1'b1;
    end
    if (gnt0_c)      pri_d = PRI1;
    else if (gnt1_c) pri_d = PRI0;
  end

  assign xfer_c      = gnt0_c | gnt1_c;
  assign sel_we_c    = gnt1_c ? bus.we1    : bus.we0;
  assign sel_addr_c  = gnt1_c ? bus.addr1  : bus.addr0;
  assign sel_wdata_c = gnt1_c ? bus.wdata1 : bus.wdata0;

  // RAM command register plus read-tracking pipe aligned to the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      cs_q <= xfer_c;
      we_q <= xfer_c & sel_we_c;
      if (xfer_c) begin
        addr_q <= sel_addr_c;
        din_q  <= sel_wdata_c;
      end
      for (int i = PIPE_TOP; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
      pipe_vld_q[0] <= xfer_c & ~sel_we_c;
      pipe_id_q[0]  <= gnt1_c;
      rvalid0_q     <= pipe_vld_q[RD_LAT-1] & ~pipe_id_q[RD_LAT-1];
      rvalid1_q     <= pipe_vld_q[RD_LAT-1] &  pipe_id_q[RD_LAT-1];
    end
  end

  assign bus.gnt0     = gnt0_c;
  assign bus.gnt1     = gnt1_c;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata    = bus.ram_dout;
  assign bus.ram_cs   = cs_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus a transaction-level reference model
// (grant rule, memory image, ordered return list) checked every cycle.
module tb_ram_port_arbiter;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM: read data appears RD_LAT cycles after the capture edge
  logic [DATA_W-1:0] mem   [2**ADDR_W];
  logic [DATA_W-1:0] rpipe [RD_LAT];
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    for (int i = 0; i < int'(RD_LAT); i++) rpipe[i] = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_cs === 1'b1 && bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_cs === 1'b1 && bus.ram_we === 1'b0) rpipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < int'(RD_LAT); i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.ram_dout = rpipe[RD_LAT-1];

  // Reference model state
  typedef struct { int due; int id; logic [DATA_W-1:0] data; } ret_t;
  typedef struct { int cyc; int id; logic [DATA_W-1:0] data; } obs_t;
  ret_t              pend[$];
  obs_t              obs[$];
  int                glog[$];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  int                fav;
  bit                m_cs, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  bit                xfer [2];
  int                last_gnt [2];
  int                cyc;
  int                n_assert = 0;
  int                n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int id, input bit r, input bit w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (id == 0) begin bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    else         begin bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  function automatic bit find_obs(input int c, input int id, output logic [DATA_W-1:0] d);
    d = '0;
    foreach (obs[i]) if (obs[i].cyc == c && obs[i].id == id) begin d = obs[i].data; return 1'b1; end
    return 1'b0;
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance the model
  task automatic tick();
    bit e_g0, e_g1, e_rv0, e_rv1, w;
    int id;
    logic [DATA_W-1:0] e_rd, d;
    logic [ADDR_W-1:0] a;
    ret_t r;
    @(negedge clk);
    e_g0 = 1'b0; e_g1 = 1'b0;
    if (!rst) begin
      if (bus.req0 && bus.req1) begin if (fav == 0) e_g0 = 1'b1; else e_g1 = 1'b1; end
      else if (bus.req0) e_g0 = 1'b1;
      else if (bus.req1) e_g1 = 1'b1;
    end
    chk("gnt0", 32'(bus.gnt0), 32'(e_g0));
    chk("gnt1", 32'(bus.gnt1), 32'(e_g1));
    chk("ram_cs", 32'(bus.ram_cs), 32'(m_cs));
    chk("ram_we", 32'(bus.ram_we), 32'(m_we));
    chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    chk("ram_din", 32'(bus.ram_din), 32'(m_din));
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.id == 0) e_rv0 = 1'b1; else e_rv1 = 1'b1;
      e_rd = r.data;
    end
    chk("rvalid0", 32'(bus.rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(e_rv1));
    if (e_rv0 || e_rv1) chk("rdata", 32'(bus.rdata), 32'(e_rd));
    if (bus.rvalid0 === 1'b1) obs.push_back('{cyc, 0, bus.rdata});
    if (bus.rvalid1 === 1'b1) obs.push_back('{cyc, 1, bus.rdata});
    xfer[0] = e_g0; xfer[1] = e_g1;
    if (rst) begin
      fav = 0; m_cs = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
      pend.delete();
    end else if (e_g0 || e_g1) begin
      id = e_g1 ? 1 : 0;
      w  = (id == 1) ? bus.we1    : bus.we0;
      a  = (id == 1) ? bus.addr1  : bus.addr0;
      d  = (id == 1) ? bus.wdata1 : bus.wdata0;
      m_cs = 1'b1; m_we = w; m_addr = a; m_din = d;
      if (w) ref_mem[a] = d;
      else   pend.push_back('{cyc + 1 + int'(RD_LAT), id, ref_mem[a]});
      fav = 1 - id;
      last_gnt[id] = cyc;
      glog.push_back(id);
    end else begin
      m_cs = 1'b0; m_we = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (n) tick();
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    bit found;
    int n, base;

    for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = '0;
    rst = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(posedge clk);
    #1;
    cyc = 0; fav = 0; m_cs = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
    last_gnt[0] = -1; last_gnt[1] = -1;

    // Reset, with a command presented during reset that must not be accepted
    tick();
    set_req(0, 1, 1, 6'd5, 8'hEE);
    tick();
    set_req(0, 0, 0, '0, '0);
    rst = 1'b0;
    idle(10);

    // Single master write then read of address 3
    set_req(0, 1, 1, 6'd3, 8'hA5);
    tick();
    set_req(0, 1, 0, 6'd3, 8'h00);
    tick();
    n = last_gnt[0];
    idle(4);
    found = find_obs(n + 2, 0, d);
    chk("wr_rd_found", 32'(found), 32'd1);
    chk("wr_rd_data", 32'(d), 32'hA5);

    // Preload, then contention round-robin with both requests held for six reads
    set_req(0, 1, 1, 6'd1, 8'h11);
    tick();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 1, 1, 6'd2, 8'h22);
    tick();
    set_req(0, 1, 0, 6'd1, 8'h00);
    set_req(1, 1, 0, 6'd2, 8'h00);
    base = glog.size();
    repeat (6) tick();
    idle(4);
    chk("rr_count", 32'(glog.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(glog[base + i]), 32'(i % 2));

    // Pointer hold: requester 1 alone three times, idle, then both request
    set_req(1, 1, 0, 6'd2, 8'h00);
    repeat (3) tick();
    idle(2);
    set_req(0, 1, 0, 6'd1, 8'h00);
    set_req(1, 1, 0, 6'd2, 8'h00);
    tick();
    chk("hold_first", 32'(glog[glog.size() - 1]), 32'd0);
    idle(4);

    // Write then read of address 63 back-to-back from requester 1
    set_req(1, 1, 1, 6'd63, 8'h5C);
    tick();
    n = last_gnt[1];
    set_req(1, 1, 0, 6'd63, 8'h00);
    tick();
    idle(4);
    found = find_obs(n + 3, 1, d);
    chk("wr_rd63_found", 32'(found), 32'd1);
    chk("wr_rd63_data", 32'(d), 32'h5C);

    // Reset with a read in flight
    set_req(0, 1, 0, 6'd3, 8'h00);
    tick();
    n = last_gnt[0];
    set_req(0, 0, 0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(6);
    base = 0;
    foreach (obs[i]) if (obs[i].cyc > n) base++;
    chk("rst_drop", 32'(base), 32'd0);

    // Randomised traffic with held requests and occasional resets
    for (int k = 0; k < 400; k++) begin
      for (int id = 0; id < 2; id++) begin
        bit cur;
        cur = (id == 0) ? bus.req0 : bus.req1;
        if (!cur || xfer[id]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(id, 1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)),
                    DATA_W'($urandom_range(0, 255)));
          else
            set_req(id, 0, 0, '0, '0);
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
